// File: rtl/ysyx_22041211_wbu.sv
// Write-back stage: captures one retiring instruction from the LSU, commits it to the GPR file, CSR port and instret.
// Latency: accept at edge T, commit cycle T->T+1, GPR/instret updated at edge T+1 (one instruction per 2 cycles).
// Backpressure: wbu_ready_o is low during the single commit cycle; lsu_valid_i is ignored then.
module ysyx_22041211_wbu #(
    parameter int DATA_LEN = 32,
    parameter int CNT_LEN  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lsu_valid_i,
    output logic                wbu_ready_o,
    input  logic                wd_i,
    input  logic [4:0]          wreg_i,
    input  logic [DATA_LEN-1:0] wdata_i,
    input  logic                csr_wen_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [DATA_LEN-1:0] csr_wdata_i,
    input  logic [4:0]          raddr1_i,
    input  logic [4:0]          raddr2_i,
    output logic [DATA_LEN-1:0] rdata1_o,
    output logic [DATA_LEN-1:0] rdata2_o,
    output logic                csr_wen_o,
    output logic [11:0]         csr_waddr_o,
    output logic [DATA_LEN-1:0] csr_wdata_o,
    output logic                wbu_valid_o,
    output logic [CNT_LEN-1:0]  instret_o
);

    typedef enum logic {
        WB_IDLE   = 1'b0,
        WB_COMMIT = 1'b1
    } wb_state_t;

    wb_state_t           state;
    logic                cap_wd;
    logic [4:0]          cap_wreg;
    logic [DATA_LEN-1:0] cap_wdata;
    logic                cap_csr_wen;
    logic [11:0]         cap_csr_addr;
    logic [DATA_LEN-1:0] cap_csr_wdata;
    logic [DATA_LEN-1:0] gpr [32];
    logic [CNT_LEN-1:0]  instret_q;
    logic                commit;

    assign commit = (state == WB_COMMIT);

    // Handshake FSM: capture the instruction on accept, spend exactly one cycle committing it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= WB_IDLE;
            cap_wd        <= 1'b0;
            cap_wreg      <= 5'd0;
            cap_wdata     <= '0;
            cap_csr_wen   <= 1'b0;
            cap_csr_addr  <= 12'd0;
            cap_csr_wdata <= '0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (lsu_valid_i) begin
                        cap_wd        <= wd_i;
                        cap_wreg      <= wreg_i;
                        cap_wdata     <= wdata_i;
                        cap_csr_wen   <= csr_wen_i;
                        cap_csr_addr  <= csr_addr_i;
                        cap_csr_wdata <= csr_wdata_i;
                        state         <= WB_COMMIT;
                    end
                end
                WB_COMMIT: state <= WB_IDLE;
                default:   state <= WB_IDLE;
            endcase
        end
    end

    // GPR file write at the end of the commit cycle; x0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= '0;
            end
        end else if (commit && cap_wd && (cap_wreg != 5'd0)) begin
            gpr[cap_wreg] <= cap_wdata;
        end
    end

    // Retired-instruction counter, wraps naturally at its width.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= '0;
        end else if (commit) begin
            instret_q <= instret_q + 1'b1;
        end
    end

    // Asynchronous read ports with no bypass from the pending commit.
    assign rdata1_o = (raddr1_i == 5'd0) ? '0 : gpr[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? '0 : gpr[raddr2_i];

    assign wbu_ready_o = !commit;
    assign wbu_valid_o = commit;
    assign csr_wen_o   = commit && cap_csr_wen;
    assign csr_waddr_o = commit ? cap_csr_addr  : 12'd0;
    assign csr_wdata_o = commit ? cap_csr_wdata : '0;
    assign instret_o   = instret_q;

endmodule

// File: doc/ysyx_22041211_wbu.md
Name: ysyx_22041211_wbu

Overview:
Write-back stage of the multi-cycle core. It sits directly downstream of the load/store unit.
- Accepts one retiring instruction per handshake from the LSU.
- Commits the result to the integrated 32-entry general-purpose register file.
- Drives the CSR write port.
- Counts retired instructions.
- Signals the IFU that the next fetch may start.

Parameters:
DATA_LEN, 32, width of GPRs, write data and CSR data
CNT_LEN, 64, width of the retired-instruction counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
lsu_valid_i  input  1  LSU has a finished instruction for write-back
wbu_ready_o  output  1  WBU can accept an instruction this cycle
wd_i  input  1  instruction writes a GPR
wreg_i  input  5  destination GPR index
wdata_i  input  DATA_LEN  GPR write data (ALU result or load data)
csr_wen_i  input  1  instruction writes a CSR
csr_addr_i  input  12  CSR address
csr_wdata_i  input  DATA_LEN  CSR write data
raddr1_i  input  5  GPR read address, port 1 (IDU)
raddr2_i  input  5  GPR read address, port 2 (IDU)
rdata1_o  output  DATA_LEN  GPR read data, port 1
rdata2_o  output  DATA_LEN  GPR read data, port 2
csr_wen_o  output  1  CSR write strobe
csr_waddr_o  output  12  CSR write address
csr_wdata_o  output  DATA_LEN  CSR write data
wbu_valid_o  output  1  write-back done; IFU may fetch next instruction
instret_o  output  CNT_LEN  retired-instruction count

Behaviour:
- FSM has two states: WB_IDLE and WB_COMMIT. Encoding 1'b0 / 1'b1. There are no other states.
- Reset (rst=0, asynchronous):
  - State = WB_IDLE.
  - All 32 GPRs = 0.
  - All capture registers = 0.
  - instret_o = 0.
  - Outputs while in reset: wbu_ready_o=1, wbu_valid_o=0, csr_wen_o=0, csr_waddr_o=0, csr_wdata_o=0.
- WB_IDLE:
  - wbu_ready_o=1.
  - Handshake fires when lsu_valid_i=1 at a rising edge.
  - On that edge: capture wd_i, wreg_i, wdata_i, csr_wen_i, csr_addr_i and csr_wdata_i into internal registers, then go to WB_COMMIT.
  - If lsu_valid_i=0, stay in WB_IDLE and hold the capture registers.
- WB_COMMIT (always exactly one cycle):
  - wbu_ready_o=0 and lsu_valid_i is ignored.
  - wbu_valid_o=1, decoded combinationally from state.
  - csr_wen_o = captured csr_wen; csr_waddr_o and csr_wdata_o = captured values. Outside WB_COMMIT these outputs are 0.
  - On the edge leaving WB_COMMIT:
    - If captured wd=1 and wreg≠0, write GPR[wreg] = captured wdata.
    - instret_o increments by 1.
    - State returns to WB_IDLE.
- Latency: accept at edge T. Commit cycle runs T→T+1. GPR and instret are updated at edge T+1. Maximum throughput is one instruction per 2 cycles.
- GPR reads:
  - Combinational and asynchronous.
  - Address 0 always returns 0.
  - No bypass: a read of the register being written during WB_COMMIT returns the old value until edge T+1.
- x0 writes (wd=1, wreg=0) are discarded, but the instruction still retires and instret increments.
- Instructions with wd=0 and csr_wen=0 (stores, branches) still take the full commit cycle, raise wbu_valid_o and increment instret.
- instret wraps modulo 2^CNT_LEN: all-ones + 1 → 0 with no flag.
- Reset during WB_COMMIT: pending GPR write and instret increment are dropped; the block resumes in WB_IDLE after reset release.
- Both read ports may address the same register; both return identical data.

Test Plan:
- Reset then drive a single write: rst low 3 cycles, then lsu_valid_i=1, wd_i=1, wreg_i=5, wdata_i=32'hDEADBEEF for one cycle.
  - wbu_ready_o=0 and wbu_valid_o=1 for exactly one cycle.
  - At the next edge raddr1_i=5 reads 32'hDEADBEEF and instret_o=1.
- x0 protection: wd_i=1, wreg_i=0, wdata_i=32'h12345678.
  - rdata1_o for raddr1_i=0 stays 0.
  - instret_o increments by 1.
- CSR path: csr_wen_i=1, csr_addr_i=12'h341, csr_wdata_i=32'h80000004, wd_i=0.
  - In the commit cycle: csr_wen_o=1, csr_waddr_o=12'h341, csr_wdata_o=32'h80000004.
  - All three outputs are 0 in the following cycle.
  - No GPR changes.
- Back-to-back: hold lsu_valid_i=1 for 6 cycles with wreg_i=1,2,3 and wdata_i=10,20,30, each value changing at accept.
  - Accepts occur every 2nd cycle.
  - GPR1=10, GPR2=20, GPR3=30.
  - instret_o=3.
- Reset mid-commit: accept wd_i=1, wreg_i=7, wdata_i=32'hA5A5A5A5, then pull rst low asynchronously during WB_COMMIT.
  - GPR7=0 and instret_o=0 after release.
  - State is WB_IDLE and wbu_ready_o=1.
- Same-cycle read during commit: during WB_COMMIT for wreg_i=9 (GPR9 previously 1), read raddr2_i=9.
  - Reads 1 in the commit cycle.
  - Reads the new value from the following cycle.
